// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the two-requester arbiter: default widths,
// holding-register state encoding and requester index constants.
package shared_reg_arbiter_pkg;

  localparam int DATA_W_DEF = 10;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/shared_reg_arbiter_hold_reg10.sv
// Shared holding register: DATA_W bits, clears on reset, loads on the accept strobe.
module hold_reg10
  import shared_reg_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter feeding one shared holding register with valid/ready
// handshakes on both sides and per-requester wrapping accept counters.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  state_t             r_state;
  logic               r_prio;
  logic               r_src;
  logic [CNT_W-1:0]   r_cnt0;
  logic [CNT_W-1:0]   r_cnt1;

  logic               w_can_accept;
  logic               w_grant0;
  logic               w_grant1;
  logic               w_acc0;
  logic               w_acc1;
  logic               w_load;
  logic               w_contested;
  logic [DATA_W-1:0]  w_ld_data;

  // The register frees up either when empty or when the consumer drains it this cycle.
  assign w_can_accept = (r_state == EMPTY) | out_ready;
  assign w_grant0     = req0_valid & (~req1_valid | (r_prio == REQ0));
  assign w_grant1     = req1_valid & (~req0_valid | (r_prio == REQ1));
  assign req0_ready   = ~rst & w_can_accept & w_grant0;
  assign req1_ready   = ~rst & w_can_accept & w_grant1;

  assign w_acc0      = req0_valid & req0_ready;
  assign w_acc1      = req1_valid & req1_ready;
  assign w_load      = w_acc0 | w_acc1;
  assign w_contested = req0_valid & req1_valid;
  assign w_ld_data   = w_acc1 ? req1_data : req0_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_prio  <= REQ0;
      r_src   <= REQ0;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      if (w_load) begin
        r_state <= FULL;
        r_src   <= w_acc1 ? REQ1 : REQ0;
        // Only a contested win hands priority to the loser.
        if (w_contested) begin
          r_prio <= w_acc0 ? REQ1 : REQ0;
        end
      end else if ((r_state == FULL) && out_ready) begin
        r_state <= EMPTY;
      end
      if (w_acc0) begin
        r_cnt0 <= r_cnt0 + CNT_W'(1);
      end
      if (w_acc1) begin
        r_cnt1 <= r_cnt1 + CNT_W'(1);
      end
    end
  end

  hold_reg10 #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_data (w_ld_data),
    .o_data (out_data)
  );

  assign out_valid = (r_state == FULL);
  assign out_src   = r_src;
  assign cnt0      = r_cnt0;
  assign cnt1      = r_cnt1;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed scenarios plus a constrained-random
// run, all checked against a transaction-level reference model.
module tb_shared_reg_arbiter;

  localparam int DW = 10;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_src;
  logic          out_ready;
  logic [CW-1:0] cnt0, cnt1;

  int total = 0;
  int bad   = 0;

  // Reference model: what the holding register contains and who is favoured.
  bit      m_full;
  int      m_data;
  int      m_src;
  int      m_cnt [2];
  int      m_prio;

  shared_reg_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive inputs, sample readys before the edge, advance the model.
  task automatic cycle(input logic rs, input logic v0, input logic [DW-1:0] d0,
                       input logic v1, input logic [DW-1:0] d1, input logic ordy,
                       output logic r0, output logic r1, output logic e0, output logic e1);
    int win;
    rst = rs; req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1; out_ready = ordy;
    #2;
    r0 = req0_ready;
    r1 = req1_ready;
    win = -1;
    if (!rs && (!m_full || ordy)) begin
      if (v0 && v1) win = m_prio;
      else if (v0)  win = 0;
      else if (v1)  win = 1;
    end
    e0 = (win == 0);
    e1 = (win == 1);
    @(posedge clk);
    #1;
    if (rs) begin
      m_full = 0; m_data = 0; m_src = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_prio = 0;
    end else if (win >= 0) begin
      m_full = 1;
      m_data = (win == 0) ? int'(d0) : int'(d1);
      m_src  = win;
      m_cnt[win] = (m_cnt[win] + 1) % (1 << CW);
      if (v0 && v1) m_prio = 1 - win;
    end else if (m_full && ordy) begin
      m_full = 0;
    end
  endtask

  task automatic do_reset();
    logic r0, r1, e0, e1;
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, r0, r1, e0, e1);
  endtask

  task automatic test_reset();
    logic r0, r1, e0, e1;
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    total++; if (out_data !== 10'h000) begin bad++; $display("FAIL reset_data got=%h want=000", out_data); end
    total++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", cnt0, cnt1); end
    cycle(1'b0, 1'b1, 10'h011, 1'b1, 10'h022, 1'b1, r0, r1, e0, e1);
    total++; if (r0 !== 1'b1 || r1 !== 1'b0) begin bad++; $display("FAIL reset_first_grant got=%b%b want=10", r0, r1); end
    total++; if (out_data !== 10'h011 || out_src !== 1'b0) begin bad++; $display("FAIL reset_first_load got=%h/%0b want=011/0", out_data, out_src); end
  endtask

  task automatic test_contention();
    logic r0, r1, e0, e1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 10'h155, 1'b1, 10'h2AA, 1'b1, r0, r1, e0, e1);
      total++;
      if (out_src !== 1'(i % 2) || out_data !== ((i % 2 == 0) ? 10'h155 : 10'h2AA) || out_valid !== 1'b1) begin
        bad++; $display("FAIL contention_%0d got src=%0b data=%h want src=%0d", i, out_src, out_data, i % 2);
      end
    end
    total++; if (cnt0 !== 8'd2 || cnt1 !== 8'd2) begin bad++; $display("FAIL contention_cnt got=%0d/%0d want=2/2", cnt0, cnt1); end
  endtask

  task automatic test_backpressure();
    logic r0, r1, e0, e1;
    int stuck;
    do_reset();
    cycle(1'b0, 1'b0, '0, 1'b1, 10'h3FF, 1'b1, r0, r1, e0, e1);
    stuck = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 10'h123, 1'b0, '0, 1'b0, r0, r1, e0, e1);
      if (r0 !== 1'b0 || out_data !== 10'h3FF || out_src !== 1'b1 || out_valid !== 1'b1) stuck++;
    end
    total++; if (stuck != 0) begin bad++; $display("FAIL backpressure_hold got=%0d bad cycles want=0 (data=%h src=%0b)", stuck, out_data, out_src); end
    cycle(1'b0, 1'b1, 10'h123, 1'b0, '0, 1'b1, r0, r1, e0, e1);
    total++; if (r0 !== 1'b1) begin bad++; $display("FAIL backpressure_release got=%0b want=1", r0); end
    total++; if (out_data !== 10'h123 || out_src !== 1'b0) begin bad++; $display("FAIL backpressure_load got=%h/%0b want=123/0", out_data, out_src); end
  endtask

  task automatic test_drain_refill();
    logic r0, r1, e0, e1;
    do_reset();
    cycle(1'b0, 1'b1, 10'h001, 1'b0, '0, 1'b1, r0, r1, e0, e1);
    cycle(1'b0, 1'b1, 10'h002, 1'b0, '0, 1'b1, r0, r1, e0, e1);
    total++; if (r0 !== 1'b1) begin bad++; $display("FAIL refill_ready got=%0b want=1", r0); end
    total++; if (out_valid !== 1'b1 || out_data !== 10'h002) begin bad++; $display("FAIL refill_data got=%0b/%h want=1/002", out_valid, out_data); end
    cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, r0, r1, e0, e1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0b want=0", out_valid); end
  endtask

  task automatic test_wrap();
    logic r0, r1, e0, e1;
    do_reset();
    for (int i = 0; i < 256; i++)
      cycle(1'b0, 1'b1, 10'(i), 1'b0, '0, 1'b1, r0, r1, e0, e1);
    total++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin bad++; $display("FAIL wrap_cnt got=%0d/%0d want=0/0", cnt0, cnt1); end
    cycle(1'b0, 1'b1, 10'h0F0, 1'b1, 10'h00F, 1'b1, r0, r1, e0, e1);
    total++; if (r0 !== 1'b1 || r1 !== 1'b0) begin bad++; $display("FAIL wrap_prio got=%b%b want=10", r0, r1); end
    total++; if (cnt0 !== 8'd1) begin bad++; $display("FAIL wrap_cnt_after got=%0d want=1", cnt0); end
  endtask

  task automatic test_reset_mid();
    logic r0, r1, e0, e1;
    do_reset();
    cycle(1'b0, 1'b1, 10'h0AB, 1'b1, 10'h0CD, 1'b0, r0, r1, e0, e1);
    cycle(1'b1, 1'b0, '0, 1'b1, 10'h0CD, 1'b1, r0, r1, e0, e1);
    total++; if (r1 !== 1'b0 || r0 !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b%b want=00", r0, r1); end
    total++; if (out_valid !== 1'b0 || out_data !== 10'h000) begin bad++; $display("FAIL rstmid_out got=%0b/%h want=0/000", out_valid, out_data); end
    total++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin bad++; $display("FAIL rstmid_cnt got=%0d/%0d want=0/0", cnt0, cnt1); end
    cycle(1'b0, 1'b1, 10'h0AA, 1'b1, 10'h0CD, 1'b1, r0, r1, e0, e1);
    total++; if (r0 !== 1'b1 || r1 !== 1'b0) begin bad++; $display("FAIL rstmid_prio got=%b%b want=10", r0, r1); end
  endtask

  task automatic test_random();
    logic r0, r1, e0, e1;
    logic v0, v1, ordy, rs;
    logic [DW-1:0] d0, d1;
    int errs;
    do_reset();
    v0 = 0; v1 = 0; d0 = '0; d1 = '0; errs = 0;
    for (int i = 0; i < 400; i++) begin
      if (!v0 && ($urandom_range(3) != 0)) begin v0 = 1; d0 = DW'($urandom); end
      if (!v1 && ($urandom_range(3) != 0)) begin v1 = 1; d1 = DW'($urandom); end
      ordy = ($urandom_range(3) != 0);
      rs   = ($urandom_range(99) == 0);
      cycle(rs, v0, d0, v1, d1, ordy, r0, r1, e0, e1);
      if (r0 !== e0 || r1 !== e1 || out_valid !== m_full || cnt0 !== CW'(m_cnt[0]) || cnt1 !== CW'(m_cnt[1]) ||
          (m_full && (out_data !== DW'(m_data) || out_src !== 1'(m_src)))) begin
        errs++;
        if (errs <= 5)
          $display("FAIL random_%0d got rdy=%b%b v=%0b d=%h s=%0b c=%0d/%0d want rdy=%b%b v=%0b d=%h s=%0d c=%0d/%0d",
                   i, r0, r1, out_valid, out_data, out_src, cnt0, cnt1, e0, e1, m_full, m_data, m_src, m_cnt[0], m_cnt[1]);
      end
      if (e0) v0 = 0;
      if (e1) v1 = 0;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL random_total got=%0d errors want=0", errs); end
  endtask

  initial begin
    rst = 1'b1; req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0; out_ready = 0;
    m_full = 0; m_data = 0; m_src = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_prio = 0;
    test_reset();
    test_contention();
    test_backpressure();
    test_drain_refill();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Two-requester round-robin arbiter and sequencer for a shared 10-bit holding register. Each cycle it grants at most one requester, loads that requester's word into the holding register, and presents the word downstream with valid/ready flow control. It sits between two producer stages of the datapath and the single consumer that shares the 10-bit register resource.

## Interface
Parameters:
- DATA_W, 10, width of the shared register and data ports
- CNT_W, 8, width of each per-requester accept counter (wraps)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous and active-high
- req0_valid  in  1  requester 0 has a word
- req0_data  in  DATA_W  requester 0 word
- req0_ready  out  1  requester 0 word accepted this cycle when high together with req0_valid
- req1_valid  in  1  requester 1 has a word
- req1_data  in  DATA_W  requester 1 word
- req1_ready  out  1  requester 1 word accepted this cycle when high together with req1_valid
- out_valid  out  1  holding register contains a word
- out_data  out  DATA_W  holding register contents
- out_src  out  1  index of the requester that supplied out_data
- out_ready  in  1  consumer takes out_data this cycle
- cnt0  out  CNT_W  number of words accepted from requester 0, modulo 2^CNT_W
- cnt1  out  CNT_W  number of words accepted from requester 1, modulo 2^CNT_W

## Operation
- State machine with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_accept = (state==EMPTY) | out_ready.
- Grant:
  - only one requester valid -> that requester is granted.
  - both valid -> the requester with priority is granted.
  - neither valid -> no grant.
- reqN_ready = can_accept & grantN. At most one ready is high per cycle. ready may depend on valid, so a requester must not wait for ready before asserting valid.
- A requester holds valid and data stable until it is accepted.
- Accept (reqN_valid & reqN_ready):
  - holding register <= reqN_data, out_src <= N, cntN <= cntN+1 (wraps from 2^CNT_W-1 to 0).
  - next state is FULL.
- Drain without accept (FULL & out_ready & no grant): next state EMPTY. out_data keeps its old value but is don't-care.
- FULL & !out_ready: register, out_src and state hold. Both readys are 0.
- Simultaneous drain and accept in FULL: the consumer takes the old word, the new word is loaded in the same edge, and the state stays FULL. This gives full throughput.
- Priority pointer:
  - updates only on a contested accept (both valid at the accept edge); priority passes to the non-granted requester.
  - an uncontested accept leaves the pointer unchanged.
- Reset values: out_valid=0, out_data=0, out_src=0, cnt0=0, cnt1=0, state=EMPTY, priority=requester 0.
- Reset asserted mid-operation discards any held word on that edge. No ready is honoured in a cycle where rst=1: readys are forced to 0 and nothing is counted.

## Timing
- Latency: a word accepted at edge k is visible on out_data/out_valid from edge k (registered output), i.e. one cycle after it was offered with ready high.
- Throughput: one word per cycle when out_ready stays high. Under sustained contention, the requesters alternate 0,1,0,1...
- reqN_ready is combinational from reqN_valid, the other requester's valid, out_ready, state and the priority pointer. No combinational path exists from the data inputs to any output.
- cnt0/cnt1 update on the same edge as the accept.

## Structure
- Shared package holds DATA_W default, CNT_W default, the state enumeration {EMPTY, FULL}, and the requester index constants REQ0=0, REQ1=1.
- One sub-module is natural: hold_reg10, a DATA_W-bit register with synchronous active-high reset to 0 and load enable. The controller drives load with the accept strobe and the data mux output.
- Grant logic, FSM, priority pointer and counters live in shared_reg_arbiter itself.

## Test plan
- Reset then idle: after rst, out_valid=0, out_data=0, cnt0=cnt1=0; both valid with out_ready=1 -> req0_ready=1, req1_ready=0 first (priority 0).
- Sustained contention: both valid every cycle with data 0x155/0x2AA and out_ready=1 -> out_src sequence 0,1,0,1, out_data alternates 0x155/0x2AA; after 4 accepts cnt0=2, cnt1=2.
- Backpressure: load 0x3FF from req1, then hold out_ready=0 for 5 cycles with req0 valid -> out_data stays 0x3FF, out_src=1, req0_ready=0 throughout; raise out_ready -> req0 accepted in that cycle.
- Simultaneous drain/refill: FULL with 0x001, out_ready=1, req0 offers 0x002 -> next cycle out_data=0x002, out_valid stays 1, no EMPTY cycle.
- Counter wrap: 256 accepts from req0 only with CNT_W=8 -> cnt0 returns to 0 and the priority pointer is unchanged (still 0).
- Reset mid-operation: FULL with 0x0AB and req1 valid, assert rst for one cycle -> req1_ready=0 in that cycle, then out_valid=0, out_data=0, counters 0, priority back to requester 0.
